// File: rtl/shreg_pkg.sv
// Shared definitions for the shift-register transmit scheduler:
// register command encoding, scheduler state type and the arbitration rule.
package shreg_pkg;

    // Command driven into the shift register every cycle.
    localparam logic [1:0] SEL_IDLE = 2'b00;  // hold contents
    localparam logic [1:0] SEL_LOAD = 2'b01;  // parallel load
    localparam logic [1:0] SEL_SHR  = 2'b10;  // shift right, 0 into MSB
    localparam logic [1:0] SEL_CLR  = 2'b11;  // force to zero

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        CLEAR = 2'b11
    } tx_state_t;

    // Round-robin pick between two requesters: a lone requester wins,
    // under contention the one that was not granted last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_id);
        logic winner;
        winner = 1'b0;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end else begin
            winner = ~last_id;
        end
        return winner;
    endfunction

endpackage

// File: rtl/shreg_core.sv
// WIDTH-bit shift register executing the sel command each cycle:
// hold, parallel load, shift right with zero fill, or clear.
module shreg_core
    import shreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] pdata,
    output logic             lsb
);

    logic [WIDTH-1:0] data;

    // Register update according to the command; reset empties the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            case (sel)
                SEL_LOAD: data <= pdata;
                SEL_SHR:  data <= {1'b0, data[WIDTH-1:1]};
                SEL_CLR:  data <= '0;
                default:  data <= data;
            endcase
        end
    end

    // Only the LSB leaves the register: it is the bit on the serial line.
    assign lsb = data[0];

endmodule

// File: rtl/shreg_tx_sched.sv
// Two-requester round-robin scheduler sharing one shift register for
// parallel-to-serial transmission.
// Serial handshake: a bit is transferred on every rising edge where
// ser_valid & ser_ready are both high; while ser_valid is high and ser_ready
// is low, ser_out and ser_last hold steady and the register does not move.
module shreg_tx_sched
    import shreg_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] pdata0,
    input  logic [WIDTH-1:0] pdata1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             done,
    output logic             done_id,
    output logic [1:0]       sel
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    tx_state_t        state;
    tx_state_t        state_nxt;
    logic [CW-1:0]    cnt;
    logic             last_id;
    logic             last_accept;
    logic             reg_lsb;
    logic [WIDTH-1:0] load_word;

    // Word of the granted requester feeds the parallel load.
    assign load_word = grant[1] ? pdata1 : pdata0;

    shreg_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .pdata (load_word),
        .lsb   (reg_lsb)
    );

    // Next state, register command and serial handshake outputs.
    always_comb begin
        state_nxt   = state;
        sel         = SEL_IDLE;
        ser_valid   = 1'b0;
        ser_last    = 1'b0;
        last_accept = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sel       = SEL_LOAD;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_last  = (cnt == LAST_CNT);
                if (ser_ready) begin
                    sel = SEL_SHR;
                    if (cnt == LAST_CNT) begin
                        last_accept = 1'b1;
                        state_nxt   = CLEAR_EN ? CLEAR : IDLE;
                    end
                end
            end
            CLEAR: begin
                sel       = SEL_CLR;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Serial line is forced low whenever no bit is being offered.
    assign ser_out = ser_valid & reg_lsb;
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit counter: cleared on load, advanced per accepted bit, never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == LOAD) begin
            cnt <= '0;
        end else if (state == SHIFT && ser_ready && cnt != LAST_CNT) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Arbiter: grant registered on leaving IDLE, dropped as done pulses.
    // last_id resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant   <= 2'b00;
            last_id <= 1'b1;
        end else if (state == IDLE && |req) begin
            grant   <= rr_pick(req, last_id) ? 2'b10 : 2'b01;
            last_id <= rr_pick(req, last_id);
        end else if (last_accept) begin
            grant <= 2'b00;
        end
    end

    // Completion pulse one cycle after the last bit is accepted; id is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            done <= last_accept;
            if (last_accept) begin
                done_id <= grant[1];
            end
        end
    end

endmodule

// File: tb/tb_shreg_tx_sched.sv
// Bench for shreg_tx_sched: two instances (WIDTH=4 with clear cycle, WIDTH=8
// without) share one stimulus stream and are compared every cycle against a
// transfer-level model, plus directed literal expectations.
module tb_shreg_tx_sched;

    // ---------------- clock / reset / stimulus signals ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] pd0 = 8'h00;
    logic [7:0] pd1 = 8'h00;
    logic       ser_ready = 1'b1;

    always #5 clk = ~clk;

    logic [1:0] grant_w[2];
    logic       busy_w[2];
    logic       ser_out_w[2];
    logic       ser_valid_w[2];
    logic       ser_last_w[2];
    logic       done_w[2];
    logic       done_id_w[2];
    logic [1:0] sel_w[2];

    shreg_tx_sched #(.WIDTH(4), .CLEAR_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .pdata0(pd0[3:0]), .pdata1(pd1[3:0]),
        .grant(grant_w[0]), .busy(busy_w[0]), .ser_out(ser_out_w[0]),
        .ser_valid(ser_valid_w[0]), .ser_ready(ser_ready),
        .ser_last(ser_last_w[0]), .done(done_w[0]), .done_id(done_id_w[0]),
        .sel(sel_w[0])
    );

    shreg_tx_sched #(.WIDTH(8), .CLEAR_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .pdata0(pd0), .pdata1(pd1),
        .grant(grant_w[1]), .busy(busy_w[1]), .ser_out(ser_out_w[1]),
        .ser_valid(ser_valid_w[1]), .ser_ready(ser_ready),
        .ser_last(ser_last_w[1]), .done(done_w[1]), .done_id(done_id_w[1]),
        .sel(sel_w[1])
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transfer-level model ----------------
    // phase: 0 idle, 1 load, 2 sending bit idx of word, 3 clear
    int         wd[2] = '{4, 8};
    bit         clr_en[2] = '{1'b1, 1'b0};
    int         m_phase[2];
    int         m_id[2];
    int         m_last[2];
    int         m_idx[2];
    logic [7:0] m_word[2];
    logic       m_done[2];
    logic       m_done_id[2];

    task automatic model_reset(input int k);
        m_phase[k] = 0;
        m_id[k] = 0;
        m_last[k] = 1;
        m_idx[k] = 0;
        m_word[k] = 8'h00;
        m_done[k] = 1'b0;
        m_done_id[k] = 1'b0;
    endtask

    task automatic model_compare(input int k);
        int e_grant;
        int e_valid;
        int e_out;
        int e_last;
        int e_sel;
        e_grant = (m_phase[k] == 1 || m_phase[k] == 2) ? (m_id[k] == 1 ? 2 : 1) : 0;
        e_valid = (m_phase[k] == 2) ? 1 : 0;
        e_out   = e_valid ? int'(m_word[k][m_idx[k]]) : 0;
        e_last  = (e_valid == 1 && m_idx[k] == wd[k] - 1) ? 1 : 0;
        case (m_phase[k])
            1:       e_sel = 1;
            2:       e_sel = ser_ready ? 2 : 0;
            3:       e_sel = 3;
            default: e_sel = 0;
        endcase
        chk($sformatf("m%0d_grant", k), grant_w[k], e_grant);
        chk($sformatf("m%0d_busy", k), busy_w[k], (m_phase[k] != 0) ? 1 : 0);
        chk($sformatf("m%0d_ser_valid", k), ser_valid_w[k], e_valid);
        chk($sformatf("m%0d_ser_out", k), ser_out_w[k], e_out);
        chk($sformatf("m%0d_ser_last", k), ser_last_w[k], e_last);
        chk($sformatf("m%0d_sel", k), sel_w[k], e_sel);
        chk($sformatf("m%0d_done", k), done_w[k], m_done[k]);
        chk($sformatf("m%0d_done_id", k), done_id_w[k], m_done_id[k]);
    endtask

    task automatic model_step(input int k);
        int w;
        m_done[k] = 1'b0;
        case (m_phase[k])
            0: begin
                if (req != 2'b00) begin
                    if (req == 2'b01)      w = 0;
                    else if (req == 2'b10) w = 1;
                    else                   w = (m_last[k] == 1) ? 0 : 1;
                    m_id[k] = w;
                    m_last[k] = w;
                    m_phase[k] = 1;
                end
            end
            1: begin
                m_word[k] = (m_id[k] == 1) ? pd1 : pd0;
                if (wd[k] == 4) m_word[k] = m_word[k] & 8'h0F;
                m_idx[k] = 0;
                m_phase[k] = 2;
            end
            2: begin
                if (ser_ready) begin
                    if (m_idx[k] == wd[k] - 1) begin
                        m_done[k] = 1'b1;
                        m_done_id[k] = (m_id[k] == 1);
                        m_phase[k] = clr_en[k] ? 3 : 0;
                    end else begin
                        m_idx[k]++;
                    end
                end
            end
            default: m_phase[k] = 0;
        endcase
    endtask

    // Inputs change only just after the rising edge, so the falling edge sees
    // the same values the next rising edge will sample.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            model_compare(k);
            if (rst_n) model_step(k);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        req = 2'b00;
        ser_ready = 1'b1;
        while ((busy_w[0] || busy_w[1]) && n < 100) begin
            next_cycle();
            n++;
        end
        chk("idle_timeout", (n >= 100) ? 1 : 0, 0);
        next_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    int bexp_sel[8] = '{0, 1, 2, 2, 2, 2, 3, 0};
    int bbits[4]    = '{1, 1, 0, 1};
    int h81bits[8]  = '{1, 0, 0, 0, 0, 0, 0, 1};
    logic done_ids[$];

    // ---------------- directed and random stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        ser_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_grant", grant_w[k], 0);
            chk("rst_busy", busy_w[k], 0);
            chk("rst_sel", sel_w[k], 0);
            chk("rst_ser_valid", ser_valid_w[k], 0);
            chk("rst_done_id", done_id_w[k], 0);
        end
        rst_n = 1'b1;
        next_cycle();

        // basic transfer, req dropped during LOAD
        pd0 = 8'h0B;
        req = 2'b01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("basic_sel", sel_w[0], bexp_sel[i]);
            if (i == 1) chk("basic_grant", grant_w[0], 1);
            if (i >= 2 && i <= 5) begin
                chk("basic_bit", ser_out_w[0], bbits[i-2]);
                chk("basic_last", ser_last_w[0], (i == 5) ? 1 : 0);
            end
            if (i == 6) begin
                chk("basic_done", done_w[0], 1);
                chk("basic_done_id", done_id_w[0], 0);
                chk("basic_grant_drop", grant_w[0], 0);
            end
            next_cycle();
            if (i == 0) req = 2'b00;
        end
        wait_idle();

        // WIDTH=8 without clear cycle
        pd0 = 8'h81;
        req = 2'b01;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("h81_no_clr", (sel_w[1] == 2'b11) ? 1 : 0, 0);
            if (i >= 2 && i <= 9) begin
                chk("h81_bit", ser_out_w[1], h81bits[i-2]);
                chk("h81_last", ser_last_w[1], (i == 9) ? 1 : 0);
            end
            if (i == 10) begin
                chk("h81_done", done_w[1], 1);
                chk("h81_done_sel", sel_w[1], 0);
                chk("h81_done_busy", busy_w[1], 0);
            end
            next_cycle();
            if (i == 0) req = 2'b00;
        end
        wait_idle();

        // contention: alternate starting from 0 after reset
        do_reset();
        pd0 = 8'h0A;
        pd1 = 8'h05;
        req = 2'b11;
        done_ids.delete();
        for (int i = 0; i < 80 && done_ids.size() < 4; i++) begin
            @(negedge clk);
            if (done_w[0]) done_ids.push_back(done_id_w[0]);
            next_cycle();
        end
        chk("rr_count", done_ids.size(), 4);
        for (int i = 0; i < done_ids.size(); i++) begin
            chk("rr_order", done_ids[i], i % 2);
        end
        wait_idle();

        // back-pressure before bit 2, req dropped in first SHIFT cycle
        pd0 = 8'($urandom_range(0, 255));
        req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            ser_ready = !(i >= 4 && i <= 6);
            if (i == 2) req = 2'b00;
            @(negedge clk);
            if (i >= 4 && i <= 6) begin
                chk("bp_sel", sel_w[0], 0);
                chk("bp_valid", ser_valid_w[0], 1);
                chk("bp_bit", ser_out_w[0], pd0[2]);
            end
            if (i == 9) chk("bp_done", done_w[0], 1);
            next_cycle();
        end
        wait_idle();

        // reset in the middle of a transfer
        pd0 = 8'h0F;
        req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            next_cycle();
            if (i == 0) req = 2'b00;
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst_grant", grant_w[k], 0);
            chk("mid_rst_busy", busy_w[k], 0);
            chk("mid_rst_valid", ser_valid_w[k], 0);
            chk("mid_rst_out", ser_out_w[k], 0);
            chk("mid_rst_last", ser_last_w[k], 0);
            chk("mid_rst_sel", sel_w[k], 0);
            chk("mid_rst_done", done_w[k], 0);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        req = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("post_rst_grant_a", grant_w[0], 2);
                chk("post_rst_grant_b", grant_w[1], 2);
            end
            next_cycle();
        end
        wait_idle();

        // random traffic, back-pressure and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            pd0 = 8'($urandom_range(0, 255));
            pd1 = 8'($urandom_range(0, 255));
            ser_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            next_cycle();
        end
        rst_n = 1'b1;
        wait_idle();
        repeat (2) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shreg_tx_sched.md
Name: shreg_tx_sched

Overview:
- Two-requester scheduler that shares one 4-bit shift register (sel-encoded: idle / parallel load / shift right / clear) for parallel-to-serial transmission.
- Arbitrates round-robin between requesters and sequences the register through load → shift → clear.
- Presents the serial stream with a valid/ready handshake.
- Sits between the PISO-style datapath and any two word producers that need a single shared serial output.

Parameters:
- WIDTH, 4, shift register width and bits per transfer; must be ≥2.
- CLEAR_EN, 1, 1 = run one CLEAR cycle (register forced to 0) after every transfer; 0 = return directly to IDLE.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  request per requester, level-sensitive
- pdata0  in  WIDTH  word offered by requester 0
- pdata1  in  WIDTH  word offered by requester 1
- grant  out  2  one-hot, held for the entire transfer
- busy  out  1  high in any state other than IDLE
- ser_out  out  1  current serial bit, LSB first
- ser_valid  out  1  ser_out carries a bit
- ser_ready  in  1  consumer accepts the bit when ser_valid & ser_ready
- ser_last  out  1  with ser_valid on the final (MSB) bit
- done  out  1  one-cycle pulse when a transfer completes
- done_id  out  1  requester index for done; holds its value between pulses
- sel  out  2  register command, exported for observation: 00 idle, 01 load, 10 shift, 11 clear

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, register = 0, bit counter = 0, rr pointer favours requester 0.
  - grant = 00, busy = 0, ser_valid = 0, ser_last = 0, ser_out = 0, done = 0, done_id = 0, sel = 00.
- Reset asserted mid-transfer aborts immediately. No done pulse is issued and the partial word is discarded.
- States: IDLE, LOAD, SHIFT, CLEAR.
- IDLE:
  - sel = 00.
  - If any req is high, pick the winner and go to LOAD. grant is registered and asserts in LOAD.
  - Only one requester high: it wins.
  - Both high: the requester not granted last wins. After reset, 0 wins.
- LOAD (1 cycle):
  - sel = 01 and grant is high.
  - The register captures pdata of the granted requester at the end of the cycle.
  - Then go to SHIFT with counter = 0.
- SHIFT:
  - ser_valid = 1 and ser_out = reg[0].
  - ser_last = 1 when counter == WIDTH-1.
  - ser_ready = 1: sel = 10 (shift right, 0 enters the MSB) and counter increments.
  - ser_ready = 0: sel = 00; register and counter hold and ser_out is stable. Back-pressure may last indefinitely.
  - When the last bit is accepted: go to CLEAR if CLEAR_EN = 1, otherwise to IDLE.
- Completion:
  - done pulses on the cycle after the last bit is accepted, and done_id = the granted index.
  - grant drops in the same cycle as the done pulse.
- CLEAR (1 cycle):
  - sel = 11, register goes to 0, done pulses, then go to IDLE.
  - With CLEAR_EN = 0, done pulses in the first IDLE cycle instead.
- Latency, from req sampled in IDLE:
  - First ser_valid appears 2 cycles later.
  - Minimum transfer is 1 + WIDTH cycles, plus 1 when CLEAR_EN = 1.
- Dropping req after grant does not abort the transfer. pdata only has to be stable during LOAD.
- New requests arriving while busy are not sampled until IDLE. No back-to-back overlap: there is at least one IDLE cycle between transfers.
- Counter width is $clog2(WIDTH); there is no wrap beyond WIDTH-1.
- ser_out is 0 whenever ser_valid = 0. The serial line is never tri-stated.

Decomposition:
- Shared package (shreg_pkg):
  - sel encoding constants SEL_IDLE = 2'b00, SEL_LOAD = 2'b01, SEL_SHR = 2'b10, SEL_CLR = 2'b11.
  - State enum typedef tx_state_t {IDLE, LOAD, SHIFT, CLEAR}.
- One sub-module: shreg_core.
  - Parameterised WIDTH register executing the sel command (hold / load / shift right with 0 fill / clear) with asynchronous active-low reset.
- The scheduler owns the FSM, the arbiter, the counter and the handshake.

Test Plan:
- Basic transfer, CLEAR_EN = 1:
  - Stimulus: reset, then req = 01 with pdata0 = 4'b1011, ser_ready = 1.
  - Response: grant = 01 in LOAD; ser_out sequence 1,1,0,1 on 4 consecutive valid cycles; ser_last on the 4th; done = 1 with done_id = 0 one cycle later; sel trace 00,01,10,10,10,10,11,00.
- Contention and round-robin:
  - Stimulus: req = 11 held with pdata0 = 4'hA, pdata1 = 4'h5.
  - Response: transfers alternate 0,1,0,…; serial words are 0,1,0,1 then 1,0,1,0; exactly one IDLE cycle between them.
- Back-pressure:
  - Stimulus: during SHIFT, ser_ready = 0 for 3 cycles before bit 2.
  - Response: sel = 00, ser_out and ser_valid stable, counter frozen; transfer completes 3 cycles late with correct bits.
- Request drop:
  - Stimulus: req0 deasserted in the SHIFT cycle after LOAD.
  - Response: all 4 bits are still sent and done pulses.
- Reset mid-transfer:
  - Stimulus: rst_n low after bit 1 is accepted.
  - Response: all outputs go to reset values asynchronously with no done pulse; after release, req = 10 is served first because the pointer is reset to favour 0 and req0 is absent.
- CLEAR_EN = 0 with WIDTH = 8:
  - Stimulus: pdata0 = 8'h81.
  - Response: bits 1,0,0,0,0,0,0,1; ser_last on the 8th; no sel = 11 ever; done in the IDLE cycle.
